// File: rtl/capture_buffer.sv
// One-shot sample capture: fills DEPTH words of block RAM, then replays them in order
// over a valid/ready port once the downstream FSM asserts read. Only reset re-arms it.
module capture_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              full,
    input  logic              read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, FULL_WAIT, DRAIN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    count_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W-1:0]   xfer_ptr_reg;
    logic                rd_done_reg;
    logic                rd_valid_reg;
    logic [DATA_W-1:0]   rd_data_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic wr_en;
    logic issue;
    logic out_stage_ready;
    logic advance;
    logic xfer;

    // Two-stage replay pipeline: the RAM output register acts as the prefetch/skid
    // stage so a stalled consumer never loses a word and ready=1 gives one word per cycle.
    always_comb begin
        out_stage_ready = !out_valid_reg || out_ready;
        advance         = rd_valid_reg && out_stage_ready;
        xfer            = out_valid_reg && out_ready;
        wr_en           = (state_reg == FILL) && in_valid;
        issue           = (state_reg == DRAIN) && !rd_done_reg
                          && (!rd_valid_reg || out_stage_ready);
        state_next      = state_reg;
        case (state_reg)
            FILL:      if (wr_en && count_reg == LAST_COUNT) state_next = FULL_WAIT;
            FULL_WAIT: if (read) state_next = DRAIN;
            DRAIN:     if (xfer && xfer_ptr_reg == LAST_ADDR) state_next = DONE;
            DONE:      state_next = DONE;
            default:   state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            rd_done_reg   <= 1'b0;
            rd_valid_reg  <= 1'b0;
            xfer_ptr_reg  <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                count_reg <= count_reg + 1'b1;
            end
            // Pointers stop at the last address instead of wrapping.
            if (issue) begin
                if (rd_ptr_reg == LAST_ADDR) begin
                    rd_done_reg <= 1'b1;
                end else begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
            if (issue) begin
                rd_valid_reg <= 1'b1;
            end else if (advance) begin
                rd_valid_reg <= 1'b0;
            end
            if (advance) begin
                out_data_reg  <= rd_data_reg;
                out_valid_reg <= 1'b1;
            end else if (xfer) begin
                out_valid_reg <= 1'b0;
            end
            if (xfer && xfer_ptr_reg != LAST_ADDR) begin
                xfer_ptr_reg <= xfer_ptr_reg + 1'b1;
            end
        end
    end

    // Simple dual-port RAM: no reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_reg[ADDR_W-1:0]] <= in_data;
        end
        if (issue) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign full      = (state_reg != FILL);
    assign done      = (state_reg == DONE);
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer (DEPTH=8): a vector table for the fill/latency
// path plus scoreboard-driven drains covering stalls, mid-drain reset and input gaps.
module tb_capture_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              full;
    logic              read = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              done;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q [$];

    typedef struct {
        logic              iv;
        logic [DATA_W-1:0] din;
        logic              rd;
        logic              ordy;
        logic [ADDR_W:0]   ecount;
        logic              efull;
        logic              evalid;
        logic [DATA_W-1:0] edata;
        logic              edone;
    } vec_t;

    vec_t vecs [17];

    capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .full      (full),
        .read      (read),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b1;
        in_valid = 1'b0;
        read = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        chk_idle(tag);
        reset = 1'b0;
        sb_q.delete();
    endtask

    // Writes DEPTH words base..base+DEPTH-1; gaps follows the 1,0,1,1,0 valid pattern.
    task automatic fill(input logic [DATA_W-1:0] base, input bit gaps, input int read_after);
        int n = 0;
        for (int cyc = 0; cyc < 100 && n < DEPTH; cyc++) begin
            in_valid = gaps ? ((cyc % 5) != 1 && (cyc % 5) != 4) : 1'b1;
            in_data  = in_valid ? base + DATA_W'(n) : 16'hDEAD;
            if (in_valid) sb_q.push_back(in_data);
            if (read_after >= 0 && n >= read_after) read = 1'b1;
            step();
            if (in_valid) n++;
            chk("fill_count", 32'(count), 32'(n));
            chk("fill_full", 32'(full), 32'(n == DEPTH));
            chk("fill_no_out", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("fill_words", 32'(n), 32'(DEPTH));
    endtask

    task automatic drain(input bit rand_ready, input int stop_after, input bit expect_done);
        int xfers = 0;
        bit seen_valid = 1'b0;
        bit prev_stall = 1'b0;
        bit last;
        logic [DATA_W-1:0] prev_data = '0;
        read = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done || (stop_after > 0 && xfers == stop_after)) break;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (!rand_ready && seen_valid) chk("no_gap", 32'(out_valid), 32'd1);
            seen_valid = seen_valid | out_valid;
            last = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra: got word %04h expected none", out_data);
                end else begin
                    if (out_data !== sb_q[0]) begin
                        errors++;
                        $display("FAIL drain_data: got %04h expected %04h", out_data, sb_q[0]);
                    end
                    void'(sb_q.pop_front());
                end
                xfers++;
                $display("xfer %0d data %04h", xfers, out_data);
                last = (sb_q.size() == 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
            if (last) begin
                chk("done_after_last", 32'(done), 32'd1);
                chk("valid_after_last", 32'(out_valid), 32'd0);
            end
        end
        if (expect_done) begin
            chk("drain_done", 32'(done), 32'd1);
            chk("drain_left", 32'(sb_q.size()), 32'd0);
            chk("drain_full", 32'(full), 32'd1);
            chk("drain_count", 32'(count), 32'(DEPTH));
        end
    endtask

    initial begin
        int model_cnt = 0;
        // rows 0-7 fill, 8-12 overflow attempts, 13-16 read latency then one stall
        for (int i = 0; i < 17; i++) begin
            vecs[i].iv     = (i < 13);
            vecs[i].din    = (i < 8) ? DATA_W'(i + 1) : 16'hFFFF;
            vecs[i].rd     = (i >= 13);
            vecs[i].ordy   = 1'b0;
            vecs[i].ecount = (i < 8) ? 4'(i + 1) : 4'd8;
            vecs[i].efull  = (i >= 7);
            vecs[i].evalid = (i >= 15);
            vecs[i].edata  = 16'h0001;
            vecs[i].edone  = 1'b0;
        end

        do_reset(2, "rst0");
        for (int i = 0; i < 17; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            read      = vecs[i].rd;
            out_ready = vecs[i].ordy;
            if (vecs[i].iv && model_cnt < DEPTH) begin
                sb_q.push_back(vecs[i].din);
                model_cnt++;
            end
            step();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ecount));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].efull));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].evalid));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].edone));
            if (vecs[i].evalid) chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].edata));
        end
        in_valid = 1'b0;
        drain(1'b1, 0, 1'b1);

        // DONE ignores every input until reset
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        in_valid = 1'b0;
        chk("done_hold_count", 32'(count), 32'(DEPTH));
        chk("done_hold_done", 32'(done), 32'd1);
        chk("done_hold_full", 32'(full), 32'd1);
        chk("done_hold_valid", 32'(out_valid), 32'd0);

        // read raised mid-fill, consumer always ready: fixed latency, no bubbles
        do_reset(2, "rst1");
        out_ready = 1'b1;
        fill(16'h0001, 1'b0, 3);
        step();
        chk("lat_n1", 32'(out_valid), 32'd0);
        step();
        chk("lat_n2", 32'(out_valid), 32'd0);
        step();
        chk("lat_n3", 32'(out_valid), 32'd1);
        drain(1'b0, 0, 1'b1);

        // reset after three transfers, then refill with gaps and drain with random stalls
        do_reset(2, "rst2");
        fill(16'h0001, 1'b0, -1);
        drain(1'b1, 3, 1'b0);
        do_reset(1, "mid_rst");
        fill(16'h0100, 1'b1, -1);
        drain(1'b1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
